pfc_vec: RTL and testbench
==========================

Name: pfc_vec

Overview:
Parametrised next-generation program flow controller for the rk16 core. It holds the PC and selects each cycle among:
- sequential increment
- conditional or unconditional jump to the ALU result
- vectored, prioritised, nestable interrupt entry
- return-from-interrupt

Return addresses live in an internal hardware stack, so nested interrupts need no software save of the return address.

Parameters:
WIDTH, 16, PC/data width in bits
NUM_IRQ, 4, number of interrupt lines; index 0 is highest priority
STACK_DEPTH, 4, maximum nesting depth (return-stack entries)
RESET_PC, 0, PC value after reset
VEC_BASE, 16'h0010, address of vector 0
VEC_STRIDE, 4, address distance between consecutive vectors

Ports:
clk_pc  input  1  PC clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
cond  input  WIDTH  branch condition; nonzero means taken
alu  input  WIDTH  jump target
pfc_ctrl  input  2  00 increment, 01 branch if cond!=0, 10 jump, 11 reti
irq  input  NUM_IRQ  level-sensitive interrupt requests
irq_en  input  1  global interrupt enable
pc  output  WIDTH  current PC
pc_inc  output  WIDTH  pc+1, combinational, wraps modulo 2^WIDTH
intr_ra  output  WIDTH  top-of-stack return address; 0 when stack empty
intr_active  output  1  depth != 0
intr_id  output  $clog2(NUM_IRQ)  id of innermost active interrupt; 0 when none
depth  output  $clog2(STACK_DEPTH+1)  current nesting depth
err  output  1  sticky: reti executed with empty stack

Behaviour:
Reset (async, immediate):
- pc=RESET_PC, depth=0, cur_level=NUM_IRQ (no level active).
- intr_id=0, err=0, all stack entries 0.
- Reset asserted mid-nesting discards the entire stack.

next_seq:
- 00 → pc_inc
- 01 → alu if cond!=0, else pc_inc
- 10 → alu
- 11 → see reti below

Eligibility: irq[i] is eligible iff irq_en=1 and i < cur_level. Winner = lowest eligible index.

Per rising edge, first match applies:
1. pfc_ctrl=11, depth>0 (reti):
   - pc <= stack[top].ra; pop.
   - cur_level and intr_id restored from popped entry.
   - Any pending irq is ignored this cycle and re-evaluated next cycle.
2. pfc_ctrl=11, depth=0:
   - pc <= pc_inc; err <= 1.
   - No interrupt is taken this cycle.
3. Eligible irq exists and depth < STACK_DEPTH (interrupt entry):
   - Push {ra=next_seq, saved_level=cur_level, saved_id=intr_id}.
   - pc <= VEC_BASE + winner*VEC_STRIDE, truncated to WIDTH.
   - cur_level <= winner; intr_id <= winner.
   - The instruction's own branch/jump result is not lost: it becomes the return address.
4. Otherwise: pc <= next_seq.

Limits and conditions:
- depth == STACK_DEPTH: interrupts are held off (not lost, since irq is level-sensitive). No error is raised.
- Same or lower priority than the active level never preempts. irq still high after reti re-enters on the following edge.
- Latency: irq high before edge N → pc equals the vector after edge N, intr_ra = return address after edge N.
- intr_ra, intr_active, intr_id, depth are registered/derived state, valid same cycle as pc.
- err clears only on reset.
- All PC arithmetic is modulo 2^WIDTH.

Test Plan (WIDTH=16, NUM_IRQ=4, STACK_DEPTH=2, VEC_BASE=0x0010, VEC_STRIDE=4, RESET_PC=0):
1. Reset, pfc_ctrl=00, 4 edges → pc 1,2,3,4; pc_inc=pc+1. Then pfc_ctrl=01, alu=0x1234, cond=0 → pc 5; cond=1 → pc 0x1234. pfc_ctrl=10 → pc 0x1234 regardless of cond.
2. At pc=0x0005, pfc_ctrl=00, irq_en=1, irq=4'b0100 → pc=0x0018, intr_ra=0x0006, intr_id=2, depth=1. Drop irq, 2 increments, reti → pc=0x0006, depth=0, intr_active=0.
3. Nesting: in irq2 handler, raise irq[0] → pc=0x0010, depth=2. Raise irq[1] → ignored (depth full). reti → back to irq2 handler address+1. Next edge: irq[1] is taken (1<2) → pc=0x0014.
4. Priority/masking: active irq1, assert irq[3] → no entry. Assert irq[0]&irq[3] with no active level → vector 0x0010. irq_en=0 with irq=4'hF → pure increment.
5. Simultaneous: reti with irq[0] high → pc=return address this edge, entry to 0x0010 next edge. Jump with pfc_ctrl=10, alu=0x0200 and irq[1] at same edge → pc=0x0014, intr_ra=0x0200.
6. Boundary: pc=0xFFFF, 00 → pc=0x0000. reti with depth=0 → pc increments, err=1 and stays set. Assert rst mid-nesting (depth=2) → pc=0, depth=0, err=0 without clock edge.

Source files
------------

// File: rtl/pfc_vec.sv
// Program flow controller for the rk16 core.
// Holds the PC and chooses each cycle between sequential increment, a
// conditional or unconditional jump to the ALU result, vectored prioritised
// interrupt entry, and return-from-interrupt. Return addresses, the priority
// level that was active, and the interrupt id are kept on an internal stack,
// so handlers can nest without software saving the return address.
module pfc_vec #(
    parameter int unsigned          WIDTH       = 16,
    parameter int unsigned          NUM_IRQ     = 4,
    parameter int unsigned          STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0]     RESET_PC    = '0,
    parameter logic [WIDTH-1:0]     VEC_BASE    = WIDTH'(16'h0010),
    parameter int unsigned          VEC_STRIDE  = 4,
    localparam int unsigned         ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    localparam int unsigned         DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk_pc,
    input  logic                rst,
    input  logic [WIDTH-1:0]    cond,
    input  logic [WIDTH-1:0]    alu,
    input  logic [1:0]          pfc_ctrl,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                irq_en,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    pc_inc,
    output logic [WIDTH-1:0]    intr_ra,
    output logic                intr_active,
    output logic [ID_W-1:0]     intr_id,
    output logic [DEPTH_W-1:0]  depth,
    output logic                err
);

    // cur_level must be able to hold NUM_IRQ, which means "no level active".
    localparam int unsigned LVL_W = $clog2(NUM_IRQ + 1);

    localparam logic [1:0] CTRL_INC  = 2'b00;
    localparam logic [1:0] CTRL_BR   = 2'b01;
    localparam logic [1:0] CTRL_JMP  = 2'b10;
    localparam logic [1:0] CTRL_RETI = 2'b11;

    logic [WIDTH-1:0]   pc_q, pc_d;
    logic               err_q, err_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [LVL_W-1:0]   cur_level_q, cur_level_d;
    logic [ID_W-1:0]    intr_id_q, intr_id_d;

    logic [WIDTH-1:0]   ra_q  [STACK_DEPTH];
    logic [LVL_W-1:0]   lvl_q [STACK_DEPTH];
    logic [ID_W-1:0]    sid_q [STACK_DEPTH];

    logic [WIDTH-1:0]   pc_plus1;
    logic [WIDTH-1:0]   next_seq;
    logic [WIDTH-1:0]   vec_addr;
    logic [WIDTH-1:0]   top_ra;
    logic [LVL_W-1:0]   top_lvl;
    logic [ID_W-1:0]    top_id;
    logic               irq_hit;
    logic [ID_W-1:0]    irq_win;
    logic               push;

    assign pc_plus1 = pc_q + WIDTH'(1);

    // Read the top stack entry; an empty stack reads back as all zeros.
    always_comb begin
        top_ra  = '0;
        top_lvl = '0;
        top_id  = '0;
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top_ra  = ra_q[i];
                top_lvl = lvl_q[i];
                top_id  = sid_q[i];
            end
        end
    end

    // Pick the lowest-index eligible request; only levels strictly above the
    // active one may preempt.
    always_comb begin
        irq_hit = 1'b0;
        irq_win = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (irq_en && irq[i] && (LVL_W'(i) < cur_level_q)) begin
                irq_hit = 1'b1;
                irq_win = ID_W'(i);
            end
        end
    end

    assign vec_addr = VEC_BASE + (WIDTH'(VEC_STRIDE) * WIDTH'(irq_win));

    // Address the current instruction would continue to if no interrupt hit.
    always_comb begin
        next_seq = pc_plus1;
        case (pfc_ctrl)
            CTRL_INC:  next_seq = pc_plus1;
            CTRL_BR:   next_seq = (cond != '0) ? alu : pc_plus1;
            CTRL_JMP:  next_seq = alu;
            default:   next_seq = pc_plus1;
        endcase
    end

    // Decide the next PC and stack action; reti outranks interrupt entry.
    always_comb begin
        pc_d        = next_seq;
        err_d       = err_q;
        depth_d     = depth_q;
        cur_level_d = cur_level_q;
        intr_id_d   = intr_id_q;
        push        = 1'b0;
        if (pfc_ctrl == CTRL_RETI) begin
            if (depth_q != '0) begin
                pc_d        = top_ra;
                depth_d     = depth_q - DEPTH_W'(1);
                cur_level_d = top_lvl;
                intr_id_d   = top_id;
            end else begin
                pc_d  = pc_plus1;
                err_d = 1'b1;
            end
        end else if (irq_hit && (depth_q < DEPTH_W'(STACK_DEPTH))) begin
            // The branch/jump outcome is preserved as the return address.
            push        = 1'b1;
            pc_d        = vec_addr;
            depth_d     = depth_q + DEPTH_W'(1);
            cur_level_d = LVL_W'(irq_win);
            intr_id_d   = irq_win;
        end
    end

    // PC and control state registers.
    always_ff @(posedge clk_pc or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            err_q       <= 1'b0;
            depth_q     <= '0;
            cur_level_q <= LVL_W'(NUM_IRQ);
            intr_id_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            err_q       <= err_d;
            depth_q     <= depth_d;
            cur_level_q <= cur_level_d;
            intr_id_q   <= intr_id_d;
        end
    end

    // Return stack: push writes the slot just above the current top. Pops
    // leave stale contents, which are never read because depth gates reads.
    always_ff @(posedge clk_pc or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                ra_q[i]  <= '0;
                lvl_q[i] <= '0;
                sid_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                if (push && (depth_q == DEPTH_W'(i))) begin
                    ra_q[i]  <= next_seq;
                    lvl_q[i] <= cur_level_q;
                    sid_q[i] <= intr_id_q;
                end
            end
        end
    end

    assign pc          = pc_q;
    assign pc_inc      = pc_plus1;
    assign intr_ra     = top_ra;
    assign intr_active = (depth_q != '0);
    assign intr_id     = intr_id_q;
    assign depth       = depth_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pfc_vec.sv
// Scoreboard bench for pfc_vec (STACK_DEPTH=2). Stimulus drives one vector
// per cycle on the falling edge and queues the hand-computed state expected
// after the next rising edge; the monitor pops and compares after each edge.
module tb_pfc_vec;

    logic        clk_pc;
    logic        rst;
    logic [15:0] cond;
    logic [15:0] alu;
    logic [1:0]  pfc_ctrl;
    logic [3:0]  irq;
    logic        irq_en;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] intr_ra;
    logic        intr_active;
    logic [1:0]  intr_id;
    logic [1:0]  depth;
    logic        err;

    pfc_vec #(
        .WIDTH       (16),
        .NUM_IRQ     (4),
        .STACK_DEPTH (2),
        .RESET_PC    (16'h0000),
        .VEC_BASE    (16'h0010),
        .VEC_STRIDE  (4)
    ) dut (
        .clk_pc      (clk_pc),
        .rst         (rst),
        .cond        (cond),
        .alu         (alu),
        .pfc_ctrl    (pfc_ctrl),
        .irq         (irq),
        .irq_en      (irq_en),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .intr_ra     (intr_ra),
        .intr_active (intr_active),
        .intr_id     (intr_id),
        .depth       (depth),
        .err         (err)
    );

    typedef struct {
        int          vnum;
        logic [15:0] pc;
        logic [15:0] ra;
        logic [1:0]  dep;
        logic [1:0]  id;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          vcount = 0;
    logic        e_err  = 1'b0;

    initial clk_pc = 1'b0;
    always #5 clk_pc = ~clk_pc;

    task automatic chk(input string name, input int vnum, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL v%0d %s got %h want %h", vnum, name, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        logic [15:0] inc_exp;
        inc_exp = e.pc + 16'd1;
        chk("pc",          e.vnum, pc,                   e.pc);
        chk("pc_inc",      e.vnum, pc_inc,               inc_exp);
        chk("intr_ra",     e.vnum, intr_ra,              e.ra);
        chk("depth",       e.vnum, {14'd0, depth},       {14'd0, e.dep});
        chk("intr_id",     e.vnum, {14'd0, intr_id},     {14'd0, e.id});
        chk("intr_active", e.vnum, {15'd0, intr_active}, {15'd0, (e.dep != 2'd0)});
        chk("err",         e.vnum, {15'd0, err},         {15'd0, e.err});
    endtask

    // Monitor: every rising edge presents a new PC; compare against the queue.
    always @(posedge clk_pc) begin
        #1;
        if (sb_q.size() > 0) chk_all(sb_q.pop_front());
    end

    task automatic step(input logic [1:0] c, input logic [15:0] cv, input logic [15:0] a,
                        input logic [3:0] rq, input logic en,
                        input logic [15:0] epc, input logic [15:0] era,
                        input logic [1:0] edep, input logic [1:0] eid);
        exp_t e;
        pfc_ctrl = c;
        cond     = cv;
        alu      = a;
        irq      = rq;
        irq_en   = en;
        vcount++;
        e.vnum = vcount;
        e.pc   = epc;
        e.ra   = era;
        e.dep  = edep;
        e.id   = eid;
        e.err  = e_err;
        sb_q.push_back(e);
        @(negedge clk_pc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 5) begin
            @(negedge clk_pc);
            n++;
        end
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue not empty size %0d want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic chk_reset_state(input int vnum);
        exp_t e;
        e.vnum = vnum;
        e.pc   = 16'h0000;
        e.ra   = 16'h0000;
        e.dep  = 2'd0;
        e.id   = 2'd0;
        e.err  = 1'b0;
        chk_all(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        pfc_ctrl = 2'b00;
        cond     = '0;
        alu      = '0;
        irq      = '0;
        irq_en   = 1'b0;
        #2;
        chk_reset_state(0);
        @(negedge clk_pc);
        @(negedge clk_pc);
        rst = 1'b0;

        // sequential, branch, jump
        step(2'b00, 16'h0, 16'h0000, 4'h0, 1'b0, 16'h0001, 16'h0000, 2'd0, 2'd0);
        step(2'b00, 16'h0, 16'h0000, 4'h0, 1'b0, 16'h0002, 16'h0000, 2'd0, 2'd0);
        step(2'b00, 16'h0, 16'h0000, 4'h0, 1'b0, 16'h0003, 16'h0000, 2'd0, 2'd0);
        step(2'b00, 16'h0, 16'h0000, 4'h0, 1'b0, 16'h0004, 16'h0000, 2'd0, 2'd0);
        step(2'b01, 16'h0, 16'h1234, 4'h0, 1'b0, 16'h0005, 16'h0000, 2'd0, 2'd0);
        step(2'b01, 16'h1, 16'h1234, 4'h0, 1'b0, 16'h1234, 16'h0000, 2'd0, 2'd0);
        step(2'b10, 16'h0, 16'h1234, 4'h0, 1'b0, 16'h1234, 16'h0000, 2'd0, 2'd0);
        step(2'b10, 16'h0, 16'h0005, 4'h0, 1'b0, 16'h0005, 16'h0000, 2'd0, 2'd0);

        // single interrupt entry and return
        step(2'b00, 16'h0, 16'h0000, 4'b0100, 1'b1, 16'h0018, 16'h0006, 2'd1, 2'd2);
        step(2'b00, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h0019, 16'h0006, 2'd1, 2'd2);
        step(2'b00, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h001A, 16'h0006, 2'd1, 2'd2);
        step(2'b11, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h0006, 16'h0000, 2'd0, 2'd0);

        // nesting, full stack holds off irq1, re-entry after reti
        step(2'b00, 16'h0, 16'h0000, 4'b0100, 1'b1, 16'h0018, 16'h0007, 2'd1, 2'd2);
        step(2'b00, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h0019, 16'h0007, 2'd1, 2'd2);
        step(2'b00, 16'h0, 16'h0000, 4'b0001, 1'b1, 16'h0010, 16'h001A, 2'd2, 2'd0);
        step(2'b00, 16'h0, 16'h0000, 4'b0010, 1'b1, 16'h0011, 16'h001A, 2'd2, 2'd0);
        step(2'b00, 16'h0, 16'h0000, 4'b0010, 1'b1, 16'h0012, 16'h001A, 2'd2, 2'd0);
        step(2'b11, 16'h0, 16'h0000, 4'b0010, 1'b1, 16'h001A, 16'h0007, 2'd1, 2'd2);
        step(2'b00, 16'h0, 16'h0000, 4'b0010, 1'b1, 16'h0014, 16'h001B, 2'd2, 2'd1);
        step(2'b11, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h001B, 16'h0007, 2'd1, 2'd2);
        step(2'b11, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h0007, 16'h0000, 2'd0, 2'd0);

        // priority and masking
        step(2'b00, 16'h0, 16'h0000, 4'b0010, 1'b1, 16'h0014, 16'h0008, 2'd1, 2'd1);
        step(2'b00, 16'h0, 16'h0000, 4'b1000, 1'b1, 16'h0015, 16'h0008, 2'd1, 2'd1);
        step(2'b11, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h0008, 16'h0000, 2'd0, 2'd0);
        step(2'b00, 16'h0, 16'h0000, 4'b1001, 1'b1, 16'h0010, 16'h0009, 2'd1, 2'd0);
        step(2'b11, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h0009, 16'h0000, 2'd0, 2'd0);
        step(2'b00, 16'h0, 16'h0000, 4'b1111, 1'b0, 16'h000A, 16'h0000, 2'd0, 2'd0);
        step(2'b00, 16'h0, 16'h0000, 4'b1111, 1'b0, 16'h000B, 16'h0000, 2'd0, 2'd0);

        // simultaneous events
        step(2'b00, 16'h0, 16'h0000, 4'b0100, 1'b1, 16'h0018, 16'h000C, 2'd1, 2'd2);
        step(2'b11, 16'h0, 16'h0000, 4'b0001, 1'b1, 16'h000C, 16'h0000, 2'd0, 2'd0);
        step(2'b00, 16'h0, 16'h0000, 4'b0001, 1'b1, 16'h0010, 16'h000D, 2'd1, 2'd0);
        step(2'b11, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h000D, 16'h0000, 2'd0, 2'd0);
        step(2'b10, 16'h0, 16'h0200, 4'b0010, 1'b1, 16'h0014, 16'h0200, 2'd1, 2'd1);
        step(2'b11, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h0200, 16'h0000, 2'd0, 2'd0);
        step(2'b01, 16'h8, 16'h0300, 4'b0100, 1'b1, 16'h0018, 16'h0300, 2'd1, 2'd2);
        step(2'b11, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h0300, 16'h0000, 2'd0, 2'd0);

        // wrap, reti on empty stack, sticky err
        step(2'b10, 16'h0, 16'hFFFF, 4'b0000, 1'b1, 16'hFFFF, 16'h0000, 2'd0, 2'd0);
        step(2'b00, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h0000, 16'h0000, 2'd0, 2'd0);
        e_err = 1'b1;
        step(2'b11, 16'h0, 16'h0000, 4'b0001, 1'b1, 16'h0001, 16'h0000, 2'd0, 2'd0);
        step(2'b00, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h0002, 16'h0000, 2'd0, 2'd0);
        step(2'b00, 16'h0, 16'h0000, 4'b0100, 1'b1, 16'h0018, 16'h0003, 2'd1, 2'd2);
        step(2'b00, 16'h0, 16'h0000, 4'b0001, 1'b1, 16'h0010, 16'h0019, 2'd2, 2'd0);
        pfc_ctrl = 2'b00;
        irq      = 4'b0000;
        drain();

        // async reset mid-nesting, between clock edges
        @(posedge clk_pc);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_state(-1);
        @(negedge clk_pc);
        rst   = 1'b0;
        e_err = 1'b0;
        step(2'b00, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h0001, 16'h0000, 2'd0, 2'd0);
        e_err = 1'b1;
        step(2'b11, 16'h0, 16'h0000, 4'b0000, 1'b1, 16'h0002, 16'h0000, 2'd0, 2'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
